// File: rtl/fb_scan_pkg.sv
// Shared types and default sizes for the frame-buffer scan-out engine.
package fb_scan_pkg;
  localparam int unsigned FB_AW         = 20;
  localparam int unsigned FB_DW         = 24;
  localparam int unsigned FB_LINE_LOG2  = 8;
  localparam int unsigned FB_LINES_LOG2 = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
endpackage

// File: rtl/fb_scan_if.sv
// IM read port plus display-side pixel stream of the scan-out engine.
interface fb_scan_if;
  logic [fb_scan_pkg::FB_AW-1:0] im_a;
  logic                          im_rd;
  logic [fb_scan_pkg::FB_DW-1:0] im_q;
  logic                          pix_valid;
  logic                          pix_ready;
  fb_scan_pkg::rgb_t             pix_data;
  logic                          pix_sol;
  logic                          pix_eol;
  logic                          pix_eof;

  modport master (
    output im_a, im_rd, pix_valid, pix_data, pix_sol, pix_eol, pix_eof,
    input  im_q, pix_ready
  );

  modport slave (
    input  im_a, im_rd, pix_valid, pix_data, pix_sol, pix_eol, pix_eof,
    output im_q, pix_ready
  );
endinterface

// File: rtl/fb_scan_px_fifo.sv
// Two-entry synchronous pixel FIFO with synchronous flush.
module px_fifo #(
  parameter int unsigned DW = 24
) (
  input  logic          clk,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [1:0]    count
);
  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (flush) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);
endmodule

// File: rtl/fb_scan.sv
// Frame-buffer scan-out: walks a LINE x LINES frame from fb_base and streams
// tagged RGB pixels over valid/ready, reading IM with one-cycle latency.
module fb_scan import fb_scan_pkg::*; #(
  parameter int unsigned LINE_LOG2  = FB_LINE_LOG2,
  parameter int unsigned LINES_LOG2 = FB_LINES_LOG2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [FB_AW-1:0] fb_base,
  fb_scan_if.master        bus,
  output logic             busy,
  output logic             done
);
  localparam int unsigned AW = FB_AW;
  localparam int unsigned DW = FB_DW;
  localparam int unsigned PW = LINE_LOG2 + LINES_LOG2;

  state_e                state;
  state_e                state_next;
  logic                  done_next;
  logic [AW-1:0]         base_r;
  logic [LINE_LOG2-1:0]  ix;
  logic [LINE_LOG2-1:0]  ox;
  logic [LINES_LOG2-1:0] iy;
  logic [LINES_LOG2-1:0] oy;
  logic                  inflight;
  logic                  issue;
  logic                  pop;
  logic                  flush;
  logic                  fifo_empty;
  logic                  fifo_full_unused;
  logic [1:0]            fifo_count;
  logic [2:0]            occ_after;
  logic [DW-1:0]         fifo_head;

  assign flush = reset | abort;
  assign pop   = bus.pix_valid & bus.pix_ready;

  // Only issue when the returning word is sure to find a free slot.
  assign occ_after = 3'(fifo_count) + 3'(inflight) - 3'(pop);
  assign issue     = (state == ST_FETCH) && !flush && (occ_after < 3'd2);

  px_fifo #(.DW(DW)) u_fifo (
    .clk   (clk),
    .flush (flush),
    .push  (inflight),
    .pop   (pop),
    .din   (bus.im_q),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full_unused),
    .count (fifo_count)
  );

  assign bus.im_rd     = issue;
  assign bus.im_a      = base_r + AW'({iy, ix});
  assign bus.pix_valid = !fifo_empty;
  assign bus.pix_data  = rgb_t'(fifo_head);
  assign bus.pix_sol   = !fifo_empty && (ox == '0);
  assign bus.pix_eol   = !fifo_empty && (&ox);
  assign bus.pix_eof   = !fifo_empty && (&ox) && (&oy);
  assign busy          = (state != ST_IDLE);

  // State register and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
    end
  end

  // Leave DRAIN on the edge that retires the last pixel so done lands in IDLE.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_next = ST_FETCH;
      ST_FETCH: if (issue && (&{iy, ix})) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (!inflight && (fifo_empty || ((fifo_count == 2'd1) && pop))) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default:  state_next = ST_IDLE;
    endcase
    if (abort) begin
      state_next = ST_IDLE;
      done_next  = 1'b0;
    end
  end

  // Issue/output counters, base latch and in-flight flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_r   <= '0;
      ix       <= '0;
      iy       <= '0;
      ox       <= '0;
      oy       <= '0;
      inflight <= 1'b0;
    end else if (abort) begin
      ix       <= '0;
      iy       <= '0;
      ox       <= '0;
      oy       <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if ((state == ST_IDLE) && start) begin
        base_r <= fb_base;
        ix     <= '0;
        iy     <= '0;
        ox     <= '0;
        oy     <= '0;
      end
      if (issue) {iy, ix} <= PW'({iy, ix} + PW'(1));
      if (pop)   {oy, ox} <= PW'({oy, ox} + PW'(1));
    end
  end
endmodule

// File: tb/tb_fb_scan.sv
// Self-checking bench for fb_scan: random backpressure against a frame model.
module tb_fb_scan;
  import fb_scan_pkg::*;

  localparam int XL   = 8;
  localparam int YL   = 4;
  localparam int LINE = 1 << XL;
  localparam int N    = 1 << (XL + YL);

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [19:0] fb_base;
  logic        busy;
  logic        done;

  fb_scan_if bus();

  fb_scan #(.LINE_LOG2(XL), .LINES_LOG2(YL)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .fb_base(fb_base),
    .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  logic prev_busy = 1'b0;

  logic [19:0] rd_addr_q[$];
  int          rd_cyc_q[$];
  logic [26:0] pop_q[$];
  int          pop_cyc_q[$];
  int          done_cyc_q[$];
  logic [1:0]  done_busy_q[$];

  function automatic logic [23:0] mem_word(input logic [19:0] a);
    logic [31:0] t;
    t = {12'h0, a} * 32'h9E3779B1;
    return t[31:8] ^ {4'h0, a};
  endfunction

  // Expected {eof, eol, sol, data} of pixel p of a frame at base.
  function automatic logic [26:0] exp_pix(input logic [19:0] base, input int p);
    return {p == N - 1, (p % LINE) == LINE - 1, (p % LINE) == 0, mem_word(base + 20'(p))};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) bus.im_q <= bus.im_rd ? mem_word(bus.im_a) : 24'($urandom);

  always @(negedge clk) begin
    if (bus.im_rd) begin
      rd_addr_q.push_back(bus.im_a);
      rd_cyc_q.push_back(cyc);
    end
    if (bus.pix_valid && bus.pix_ready) begin
      pop_q.push_back({bus.pix_eof, bus.pix_eol, bus.pix_sol, bus.pix_data});
      pop_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cyc_q.push_back(cyc);
      done_busy_q.push_back({prev_busy, busy});
    end
    prev_busy = busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    rd_addr_q.delete(); rd_cyc_q.delete(); pop_q.delete();
    pop_cyc_q.delete(); done_cyc_q.delete(); done_busy_q.delete();
  endtask

  task automatic pulse_start(input logic [19:0] b);
    fb_base = b;
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    fb_base = 20'($urandom);
  endtask

  task automatic drive_frame(input bit rnd, input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      bus.pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (done) got = 1'b1;
      tick();
    end
    bus.pix_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; fb_base = '0; bus.pix_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({bus.im_rd, bus.im_a} !== 21'h0) begin failures++; $display("FAIL reset_im got=%h want=0", {bus.im_rd, bus.im_a}); end
    checks++; if ({bus.pix_valid, bus.pix_data} !== 25'h0) begin failures++; $display("FAIL reset_pix got=%h want=0", {bus.pix_valid, bus.pix_data}); end
    checks++; if ({bus.pix_sol, bus.pix_eol, bus.pix_eof} !== 3'b000) begin failures++; $display("FAIL reset_tags got=%b want=000", {bus.pix_sol, bus.pix_eol, bus.pix_eof}); end
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL reset_busy_done got=%b want=00", {busy, done}); end
    tick();
  endtask

  task automatic test_basic();
    bit got;
    logic [19:0] base = 20'h10000;
    clear_log();
    pulse_start(base);
    drive_frame(1'b0, N + 20, got);
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL basic_done_seen got=%0b want=1", got); end
    checks++; if (rd_addr_q.size() != N) begin failures++; $display("FAIL basic_reads got=%0d want=%0d", rd_addr_q.size(), N); end
    for (int i = 0; i < rd_addr_q.size(); i++) begin
      checks++;
      if (rd_addr_q[i] !== base + 20'(i)) begin failures++; $display("FAIL basic_addr[%0d] got=%h want=%h", i, rd_addr_q[i], base + 20'(i)); break; end
    end
    checks++; if (pop_q.size() != N) begin failures++; $display("FAIL basic_pops got=%0d want=%0d", pop_q.size(), N); end
    for (int i = 0; i < pop_q.size(); i++) begin
      checks++;
      if (pop_q[i] !== exp_pix(base, i)) begin failures++; $display("FAIL basic_pix[%0d] got=%h want=%h", i, pop_q[i], exp_pix(base, i)); break; end
    end
    checks++; if ((rd_cyc_q.size() > 0 ? rd_cyc_q[0] : -1) != start_cyc + 1) begin failures++; $display("FAIL first_rd_latency got=%0d want=%0d", rd_cyc_q.size() > 0 ? rd_cyc_q[0] - start_cyc : -1, 1); end
    checks++; if ((pop_cyc_q.size() > 0 ? pop_cyc_q[0] : -1) != start_cyc + 3) begin failures++; $display("FAIL first_valid_latency got=%0d want=%0d", pop_cyc_q.size() > 0 ? pop_cyc_q[0] - start_cyc : -1, 3); end
    checks++; if ((pop_cyc_q.size() > 0 ? pop_cyc_q[pop_cyc_q.size() - 1] : -1) != start_cyc + N + 2) begin failures++; $display("FAIL last_pop_cycle got=%0d want=%0d", pop_cyc_q.size() > 0 ? pop_cyc_q[pop_cyc_q.size() - 1] - start_cyc : -1, N + 2); end
    checks++; if (done_cyc_q.size() != 1) begin failures++; $display("FAIL basic_done_count got=%0d want=1", done_cyc_q.size()); end
    checks++; if ((done_cyc_q.size() > 0 ? done_cyc_q[0] : -1) != start_cyc + N + 3) begin failures++; $display("FAIL done_cycle got=%0d want=%0d", done_cyc_q.size() > 0 ? done_cyc_q[0] - start_cyc : -1, N + 3); end
    checks++; if ((done_busy_q.size() > 0 ? done_busy_q[0] : 2'bxx) !== 2'b10) begin failures++; $display("FAIL busy_falls_with_done got=%b want=10", done_busy_q.size() > 0 ? done_busy_q[0] : 2'bxx); end
  endtask

  task automatic test_backpressure();
    bit got;
    logic [19:0] base = 20'h23400;
    clear_log();
    bus.pix_ready = 1'b0;
    pulse_start(base);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.pix_valid) got = 1'b1; else tick();
    end
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL bp_first_valid got=%0b want=1", got); end
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      checks++; if (bus.im_rd !== 1'b0) begin failures++; $display("FAIL bp_im_rd_low[%0d] got=%b want=0", k, bus.im_rd); end
      checks++; if ({bus.pix_valid, bus.pix_sol, bus.pix_data} !== {2'b11, mem_word(base)}) begin failures++; $display("FAIL bp_frozen[%0d] got=%h want=%h", k, {bus.pix_valid, bus.pix_sol, bus.pix_data}, {2'b11, mem_word(base)}); end
      checks++; if (rd_addr_q.size() != 2) begin failures++; $display("FAIL bp_outstanding[%0d] got=%0d want=2", k, rd_addr_q.size()); end
      tick();
    end
    drive_frame(1'b1, 8 * N, got);
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL bp_done_seen got=%0b want=1", got); end
    checks++; if (pop_q.size() != N) begin failures++; $display("FAIL bp_pops got=%0d want=%0d", pop_q.size(), N); end
    for (int i = 0; i < pop_q.size(); i++) begin
      checks++;
      if (pop_q[i] !== exp_pix(base, i)) begin failures++; $display("FAIL bp_pix[%0d] got=%h want=%h", i, pop_q[i], exp_pix(base, i)); break; end
    end
    checks++; if (done_cyc_q.size() != 1) begin failures++; $display("FAIL bp_done_count got=%0d want=1", done_cyc_q.size()); end
  endtask

  task automatic test_wrap();
    bit got;
    logic [19:0] base = 20'hFFF00;
    clear_log();
    pulse_start(base);
    drive_frame(1'b0, N + 20, got);
    checks++; if (rd_addr_q.size() != N) begin failures++; $display("FAIL wrap_reads got=%0d want=%0d", rd_addr_q.size(), N); end
    checks++; if ((rd_addr_q.size() > 256 ? rd_addr_q[256] : 20'hxxxxx) !== 20'h00000) begin failures++; $display("FAIL wrap_257th got=%h want=00000", rd_addr_q.size() > 256 ? rd_addr_q[256] : 20'hxxxxx); end
    checks++; if ((rd_addr_q.size() == N ? rd_addr_q[N - 1] : 20'hxxxxx) !== base + 20'(N - 1)) begin failures++; $display("FAIL wrap_last got=%h want=%h", rd_addr_q.size() == N ? rd_addr_q[N - 1] : 20'hxxxxx, base + 20'(N - 1)); end
    for (int i = 0; i < pop_q.size(); i++) begin
      checks++;
      if (pop_q[i] !== exp_pix(base, i)) begin failures++; $display("FAIL wrap_pix[%0d] got=%h want=%h", i, pop_q[i], exp_pix(base, i)); break; end
    end
    checks++; if (got !== 1'b1 || pop_q.size() != N) begin failures++; $display("FAIL wrap_complete got=%0b/%0d want=1/%0d", got, pop_q.size(), N); end
  endtask

  task automatic test_abort();
    bit got;
    bit clean;
    clear_log();
    pulse_start(20'h30000);
    bus.pix_ready = 1'b1;
    for (int i = 0; i < N && pop_q.size() < 1000; i++) begin @(negedge clk); tick(); end
    checks++; if (pop_q.size() != 1000) begin failures++; $display("FAIL abort_prefix got=%0d want=1000", pop_q.size()); end
    bus.pix_ready = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    checks++; if ({bus.pix_valid, bus.pix_eof, bus.pix_eol, bus.pix_sol, bus.pix_data} !== {1'b1, exp_pix(20'h30000, 1000)}) begin failures++; $display("FAIL abort_pixel1000 got=%h want=%h", {bus.pix_valid, bus.pix_eof, bus.pix_eol, bus.pix_sol, bus.pix_data}, {1'b1, exp_pix(20'h30000, 1000)}); end
    tick();
    abort = 1'b0;
    @(negedge clk);
    checks++; if ({busy, bus.pix_valid, bus.im_rd} !== 3'b000) begin failures++; $display("FAIL abort_idle got=%b want=000", {busy, bus.pix_valid, bus.im_rd}); end
    clean = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      if (bus.pix_valid !== 1'b0 || done !== 1'b0) clean = 1'b0;
    end
    checks++; if (clean !== 1'b1 || done_cyc_q.size() != 0) begin failures++; $display("FAIL abort_no_done got=%0b/%0d want=1/0", clean, done_cyc_q.size()); end
    tick();
    clear_log();
    bus.pix_ready = 1'b1;
    pulse_start(20'h00000);
    drive_frame(1'b0, N + 20, got);
    checks++; if ((rd_addr_q.size() > 0 ? rd_addr_q[0] : 20'hxxxxx) !== 20'h00000) begin failures++; $display("FAIL restart_first_addr got=%h want=00000", rd_addr_q.size() > 0 ? rd_addr_q[0] : 20'hxxxxx); end
    checks++; if (pop_q.size() != N || got !== 1'b1) begin failures++; $display("FAIL restart_complete got=%0d/%0b want=%0d/1", pop_q.size(), got, N); end
    for (int i = 0; i < pop_q.size(); i++) begin
      checks++;
      if (pop_q[i] !== exp_pix(20'h00000, i)) begin failures++; $display("FAIL restart_pix[%0d] got=%h want=%h", i, pop_q[i], exp_pix(20'h00000, i)); break; end
    end
    checks++; if ((done_cyc_q.size() > 0 ? done_cyc_q[0] : -1) != start_cyc + N + 3) begin failures++; $display("FAIL restart_done_cycle got=%0d want=%0d", done_cyc_q.size() > 0 ? done_cyc_q[0] - start_cyc : -1, N + 3); end
  endtask

  task automatic test_start_ignored();
    bit got;
    logic [19:0] base = 20'h08000;
    clear_log();
    pulse_start(base);
    bus.pix_ready = 1'b1;
    repeat (500) tick();
    fb_base = 20'h55555;
    start = 1'b1;
    tick();
    start = 1'b0;
    drive_frame(1'b0, N + 20, got);
    checks++; if (rd_addr_q.size() != N) begin failures++; $display("FAIL ign_reads got=%0d want=%0d", rd_addr_q.size(), N); end
    for (int i = 0; i < rd_addr_q.size(); i++) begin
      checks++;
      if (rd_addr_q[i] !== base + 20'(i)) begin failures++; $display("FAIL ign_addr[%0d] got=%h want=%h", i, rd_addr_q[i], base + 20'(i)); break; end
    end
    checks++; if ((done_cyc_q.size() == 1 ? done_cyc_q[0] : -1) != start_cyc + N + 3) begin failures++; $display("FAIL ign_done got=%0d want=%0d", done_cyc_q.size() == 1 ? done_cyc_q[0] - start_cyc : -1, N + 3); end
  endtask

  task automatic test_back_to_back();
    bit got;
    int first_start;
    clear_log();
    pulse_start(20'h60000);
    first_start = start_cyc;
    bus.pix_ready = 1'b1;
    for (int i = 0; i < N + 10 && cyc < first_start + N + 3; i++) tick();
    fb_base = 20'h70000;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    checks++; if ({done, busy} !== 2'b10) begin failures++; $display("FAIL b2b_done_idle got=%b want=10", {done, busy}); end
    tick();
    start = 1'b0;
    @(negedge clk);
    checks++; if ({busy, bus.im_rd, bus.im_a} !== {2'b11, 20'h70000}) begin failures++; $display("FAIL b2b_restart got=%h want=%h", {busy, bus.im_rd, bus.im_a}, {2'b11, 20'h70000}); end
    tick();
    drive_frame(1'b0, N + 20, got);
    checks++; if (got !== 1'b1 || done_cyc_q.size() != 2 || rd_addr_q.size() != 2 * N) begin failures++; $display("FAIL b2b_frames got=%0b/%0d/%0d want=1/2/%0d", got, done_cyc_q.size(), rd_addr_q.size(), 2 * N); end
    checks++; if ((rd_addr_q.size() == 2 * N ? rd_addr_q[2 * N - 1] : 20'hxxxxx) !== 20'h70000 + 20'(N - 1)) begin failures++; $display("FAIL b2b_last_addr got=%h want=%h", rd_addr_q.size() == 2 * N ? rd_addr_q[2 * N - 1] : 20'hxxxxx, 20'h70000 + 20'(N - 1)); end
  endtask

  task automatic test_reset_mid();
    bit quiet;
    clear_log();
    pulse_start(20'h40000);
    for (int i = 0; i < 300; i++) begin
      bus.pix_ready = 1'($urandom_range(0, 1));
      tick();
    end
    bus.pix_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({bus.im_rd, bus.im_a} !== 21'h0) begin failures++; $display("FAIL rst_mid_im got=%h want=0", {bus.im_rd, bus.im_a}); end
    checks++; if ({bus.pix_valid, bus.pix_data} !== 25'h0) begin failures++; $display("FAIL rst_mid_pix got=%h want=0", {bus.pix_valid, bus.pix_data}); end
    checks++; if ({bus.pix_sol, bus.pix_eol, bus.pix_eof, busy, done} !== 5'b0) begin failures++; $display("FAIL rst_mid_ctrl got=%b want=00000", {bus.pix_sol, bus.pix_eol, bus.pix_eof, busy, done}); end
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || bus.pix_valid !== 1'b0) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1 || done_cyc_q.size() != 0) begin failures++; $display("FAIL rst_mid_quiet got=%0b/%0d want=1/0", quiet, done_cyc_q.size()); end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    fb_base = '0;
    bus.pix_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_abort();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
